cmd_receiver: RTL and testbench

Serial command-line receiver, the far end of the command decoder/serializer link. Watches the single-bit `cmd_line`, hunts for the 16-bit sync word 0x817E (shifted in LSB-first), then locks to 16-bit frame boundaries. Non-sync frames are split into two bytes, low byte first, and buffered in a 4-entry byte FIFO with valid/ready output. Sits on the chip/emulator side of the link and feeds the command execution logic.

---
 rtl/cmd_receiver.sv | 165 ++++++++++++++++
 tb/tb_cmd_receiver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_receiver.sv
// Serial command-line receiver: hunts for the sync word, locks to 16-bit frames and
// queues the data bytes (low byte first) in a small FIFO. Define CMD_RX_RELOCK_EN to re-align on misaligned sync words.
module cmd_receiver #(
  parameter logic [15:0] SYNC_WORD  = 16'h817E,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       cmd_line,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       locked,
  output logic       sync_seen,
  output logic       overflow,
  output logic       realign
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = CW + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t      state, state_nxt;
  logic [15:0] sr;
  logic [3:0]  phase, phase_nxt;
  logic        sync_seen_nxt, overflow_nxt;
  logic        hi_pend, hi_pend_nxt;
  logic [7:0]  hi_byte, hi_byte_nxt;

  logic          push, do_push, pop;
  logic [7:0]    push_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [FW-1:0] free_slots;
  logic          sync_match;

`ifdef CMD_RX_RELOCK_EN
  logic realign_nxt;
`endif

  assign sync_match = (sr == SYNC_WORD);
  assign data_valid = (count != '0);
  assign pop        = data_valid && data_ready;
  assign data_out   = data_valid ? mem[rd_ptr] : 8'h00;
  assign locked     = (state == LOCKED);
  // A pop in the same cycle frees a slot for the incoming frame.
  assign free_slots = FW'(FIFO_DEPTH) - FW'(count) + FW'(pop);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt     = state;
    phase_nxt     = phase;
    sync_seen_nxt = 1'b0;
    overflow_nxt  = overflow;
    hi_pend_nxt   = 1'b0;
    hi_byte_nxt   = hi_byte;
    push          = hi_pend;
    push_data     = hi_byte;
`ifdef CMD_RX_RELOCK_EN
    realign_nxt   = 1'b0;
`endif
    if (!enable) begin
      state_nxt    = HUNT;
      phase_nxt    = 4'd0;
      overflow_nxt = 1'b0;
      push         = 1'b0;
    end else begin
      unique case (state)
        HUNT: begin
          if (sync_match) begin
            state_nxt     = LOCKED;
            phase_nxt     = 4'd0;
            sync_seen_nxt = 1'b1;
          end
        end
        LOCKED: begin
          phase_nxt = phase + 4'd1;
          if (phase == 4'd15) begin
            if (sync_match) begin
              sync_seen_nxt = 1'b1;
            end else if (free_slots < FW'(2)) begin
              overflow_nxt = 1'b1;
            end else begin
              push        = 1'b1;
              push_data   = sr[7:0];
              hi_pend_nxt = 1'b1;
              hi_byte_nxt = sr[15:8];
            end
          end
`ifdef CMD_RX_RELOCK_EN
          else if (sync_match) begin
            phase_nxt     = 4'd0;
            realign_nxt   = 1'b1;
            sync_seen_nxt = 1'b1;
          end
`endif
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      phase     <= 4'd0;
      sr        <= '0;
      sync_seen <= 1'b0;
      overflow  <= 1'b0;
      hi_pend   <= 1'b0;
      hi_byte   <= 8'h00;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      sr        <= enable ? {cmd_line, sr[15:1]} : 16'h0000;
      sync_seen <= sync_seen_nxt;
      overflow  <= overflow_nxt;
      hi_pend   <= hi_pend_nxt;
      hi_byte   <= hi_byte_nxt;
    end
  end

`ifdef CMD_RX_RELOCK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) realign <= 1'b0;
    else       realign <= realign_nxt;
  end
`else
  assign realign = 1'b0;
`endif

  // Overflow logic already reserves room; the guard keeps the count in range regardless.
  assign do_push = push && ((count != CW'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; entries are only observed after a push, and data_out is masked when empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_cmd_receiver.sv
// Directed bench for cmd_receiver: acquisition, byte output timing, overflow,
// enable/reset recovery and misaligned-sync behaviour (expectations follow CMD_RX_RELOCK_EN).
module tb_cmd_receiver;

  localparam logic [15:0] SYNC = 16'h817E;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cmd_line = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, locked, sync_seen, overflow, realign;

  int tests_run = 0;
  int tests_failed = 0;

  int         cyc = 0;
  int         realign_cnt = 0;
  logic [7:0] popped[$];
  logic [7:0] exp_q[$];
  int         sync_t[$];

  cmd_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cmd_line   (cmd_line),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .locked     (locked),
    .sync_seen  (sync_seen),
    .overflow   (overflow),
    .realign    (realign)
  );

  always #5 clock = ~clock;

  // Log accepted bytes and pulses half a cycle away from the active edge.
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (data_valid && data_ready) popped.push_back(data_out);
      if (sync_seen) sync_t.push_back(cyc);
      if (realign) realign_cnt <= realign_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    cmd_line = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send_bit(w[i]);
  endtask

  task automatic restart();
    enable = 1'b0;
    send_bit(1'b0);
    enable = 1'b1;
    popped.delete();
    sync_t.delete();
  endtask

  task automatic check_popped(input string tag);
    check({tag, "_count"}, popped.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < popped.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, popped[i]}, {24'h0, exp_q[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    check("rst_data_out", {24'h0, data_out}, 32'h0);
    check("rst_valid", data_valid, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_sync_seen", sync_seen, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_realign", realign, 1'b0);
    reset = 1'b0;
    enable = 1'b1;
    data_ready = 1'b1;

    // Acquisition and first frame timing: sync completes at edge k
    send_word(SYNC);
    check("acq_not_yet", locked, 1'b0);
    w = 16'h3412;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i]);
      if (i == 0) begin
        check("acq_locked", locked, 1'b1);
        check("acq_sync_seen", sync_seen, 1'b1);
        check("acq_fifo_empty", data_valid, 1'b0);
      end
    end
    check("k16_no_pulse", sync_seen, 1'b0);
    check("k16_empty", data_valid, 1'b0);
    w = SYNC;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i]);
      if (i == 0) begin
        check("k17_valid", data_valid, 1'b1);
        check("k17_low", {24'h0, data_out}, 32'h12);
      end else if (i == 1) begin
        check("k18_valid", data_valid, 1'b1);
        check("k18_high", {24'h0, data_out}, 32'h34);
      end else if (i == 2) begin
        check("k19_empty", data_valid, 1'b0);
      end
    end

    // Data frame between two syncs: acquisition pulse and aligned-sync pulse
    restart();
    send_word(SYNC);
    send_word(16'hAAAA);
    send_word(SYNC);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    check("aa_sync_pulses", sync_t.size(), 2);
    // The aligned sync completes two frame periods after the acquisition pulse.
    if (sync_t.size() == 2) check("aa_sync_gap", sync_t[1] - sync_t[0], 32);
    exp_q = '{8'hAA, 8'hAA};
    check_popped("aa");

    // Overflow: FIFO fills with 01..04, third frame dropped
    data_ready = 1'b0;
    restart();
    send_word(SYNC);
    send_word(16'h0201);
    send_word(16'h0403);
    send_word(16'h0605);
    send_word(SYNC);
    check("ovf_set", overflow, 1'b1);
    check("ovf_valid", data_valid, 1'b1);
    check("ovf_head", {24'h0, data_out}, 32'h01);
    data_ready = 1'b1;
    send_word(SYNC);
    check("ovf_drained", data_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_popped("ovf");

    // Mid-frame enable drop, then reacquire
    w = 16'h00FF;
    for (int i = 0; i < 6; i++) send_bit(w[i]);
    enable = 1'b0;
    send_bit(1'b0);
    check("en_low_unlocked", locked, 1'b0);
    check("en_low_ovf_clr", overflow, 1'b0);
    check("en_low_empty", data_valid, 1'b0);
    enable = 1'b1;
    popped.delete();
    send_word(SYNC);
    check("reacq_not_yet", locked, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_bit(w[i]);
      if (i == 0) check("reacq_locked", locked, 1'b1);
    end
    send_word(SYNC);
    check("reacq_ovf", overflow, 1'b0);
    exp_q = '{8'hFF, 8'h00};
    check_popped("reacq");

    // Five stray bits, then sync and 0x5A5A
    restart();
    realign_cnt = 0;
    send_word(SYNC);
    send_word(SYNC);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_word(SYNC);
    send_word(16'h5A5A);
    send_word(SYNC);
    send_bit(1'b0);
`ifdef CMD_RX_RELOCK_EN
    exp_q = '{8'hC0, 8'h2F, 8'h5A, 8'h5A};
    check("slip_realign", realign_cnt, 1);
`else
    exp_q = '{8'hC0, 8'h2F, 8'h50, 8'h4B, 8'hCB, 8'h2F};
    check("slip_realign", realign_cnt, 0);
`endif
    check_popped("slip");

    // Asynchronous reset mid-frame, then normal reception resumes
    check("pre_rst_locked", locked, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_locked", locked, 1'b0);
    check("arst_valid", data_valid, 1'b0);
    check("arst_sync_seen", sync_seen, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    popped.delete();
    send_word(SYNC);
    send_word(16'h7788);
    send_word(SYNC);
    check("post_rst_locked", locked, 1'b1);
    exp_q = '{8'h88, 8'h77};
    check_popped("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
